peripheral_mpram_axi4_bridge: RTL and testbench
===============================================

Name: peripheral_mpram_axi4_bridge

Overview:
- AXI4 subordinate front-end that drives the single-port MPRAM memory port (req/we/be/addr/data, 1-cycle registered read data).
- Converts AXI4 INCR bursts into one RAM access per beat.
- Sits between the interconnect and the MPRAM macro.
- Handles one transaction at a time; write has priority over read.

Parameters:
AXI_ADDR_WIDTH, 10, RAM word-address width; AXI byte address is AXI_ADDR_WIDTH+log2(AXI_DATA_WIDTH/8) bits (BAW)
AXI_DATA_WIDTH, 32, data width, multiple of 8
AXI_ID_WIDTH, 4, transaction ID width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
awid_i, arid_i  input  AXI_ID_WIDTH  request IDs
awaddr_i, araddr_i  input  BAW  byte start address
awlen_i, arlen_i  input  8  beats-1
awburst_i, arburst_i  input  2  burst type
awvalid_i, arvalid_i  input  1  address valid
awready_o, arready_o  output  1  address ready
wdata_i  input  AXI_DATA_WIDTH  write data
wstrb_i  input  AXI_DATA_WIDTH/8  byte strobes
wlast_i, wvalid_i  input  1  last beat / valid
wready_o  output  1  write ready
bid_o, rid_o  output  AXI_ID_WIDTH  response IDs
bresp_o, rresp_o  output  2  responses
bvalid_o  output  1  write response valid; bready_i input 1
rdata_o  output  AXI_DATA_WIDTH  read data
rlast_o, rvalid_o  output  1  last / valid; rready_i input 1
mem_req_o, mem_we_o  output  1  RAM request / write enable
mem_be_o  output  AXI_DATA_WIDTH/8  RAM byte enables
mem_addr_o  output  AXI_ADDR_WIDTH  RAM word address
mem_data_o  output  AXI_DATA_WIDTH  RAM write data
mem_data_i  input  AXI_DATA_WIDTH  RAM read data, valid the cycle after a read request

Behaviour:
- One clock (clk_i); reset is synchronous, active-high on rst_i.
- Reset, including mid-burst: state IDLE, all valid/ready/req/we outputs 0, IDs/resp/data/addr outputs 0. Burst is abandoned; no B or R is issued for it.
- States:
  - IDLE: awready_o=arready_o=1 only when awvalid_i or arvalid_i is high; if both are valid, AW is accepted and AR is not.
  - AW handshake: capture id, word address (byte addr >> log2(AXI_DATA_WIDTH/8)), len, burst; clear beat counter; -> WBEAT.
  - AR handshake: capture the same fields -> RREQ.
  - WBEAT: wready_o=1. On wvalid_i: same-cycle mem_req_o=1, mem_we_o=1, mem_be_o=wstrb_i, mem_data_o=wdata_i, mem_addr_o=current address; address+1, counter+1. The beat with counter==len -> BRESP.
  - BRESP: bvalid_o=1, bid_o=captured id; hold until bready_i -> IDLE.
  - RREQ: mem_req_o=1, mem_we_o=0, mem_addr_o=current address -> RDATA next cycle.
  - RDATA: rvalid_o=1, rdata_o=mem_data_i, rid_o=id, rlast_o=(counter==len). mem_addr_o is held so RAM output stays stable while stalled. On rready_i: if last -> IDLE, else address+1, counter+1 -> RREQ.
- Throughput: 1 write beat/cycle; 1 read beat per 2 cycles.
- Responses: rresp_o is always OKAY (2'b00). bresp_o is SLVERR (2'b10) if wlast_i disagreed with (counter==len) on any beat, otherwise OKAY. The beat counter, not wlast_i, terminates the burst.
- Burst types: FIXED (00) and reserved (11) are treated as INCR.
- Address wrap: the word address increments modulo 2**AXI_ADDR_WIDTH (top wraps to 0). Byte-offset bits are ignored.
- mem_req_o is never asserted in IDLE or BRESP.

Optional Feature:
- Macro: PERIPHERAL_MPRAM_AXI4_WRAP_EN.
- Defined: burst 2'b10 (WRAP) wraps the word address within an aligned block of len+1 beats. len must be 1, 3, 7 or 15; any other len with WRAP gives SLVERR on B/R while the access still proceeds as INCR.
- Not defined: WRAP is treated as INCR.

Test Plan:
- Write awaddr=0x10, awlen=3, wdata 0xA0..0xA3, wstrb=0xF, then read the same range -> mem addr 4,5,6,7 written; R returns 0xA0..0xA3, rlast on beat 4, rresp OKAY.
- Single write wstrb=0b0101, data 0x11223344 over a word preloaded with 0xFFFFFFFF -> readback 0xFF22FF44.
- awvalid and arvalid asserted in the same cycle -> AW accepted first, AR accepted only after bvalid/bready completes.
- Read with rready_i low for 5 cycles -> rdata_o stable, mem_addr_o constant, no extra mem_req_o pulses.
- Write with awlen=1 and wlast_i asserted on beat 0 -> 2 beats written, bresp=SLVERR.
- rst_i pulsed during beat 2 of a 4-beat read -> next cycle rvalid_o=0, IDLE; a fresh read completes normally.
- WRAP_EN defined: WRAP burst, awlen=3, word addr 6 -> writes to 6,7,4,5.

Source files
------------

// File: rtl/peripheral_mpram_axi4_bridge.sv
// rtl/peripheral_mpram_axi4_bridge.sv - AXI4 subordinate bridge onto a single-port MPRAM
//
// Purpose: accepts one AXI4 transaction at a time (AW wins over AR) and turns
// every burst beat into one RAM access. Writes run at one beat per cycle; reads
// take two cycles per beat because the RAM returns data one cycle after the request.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   aw*_i / awready_o            write address channel (id, byte addr, len, burst)
//   w*_i  / wready_o             write data channel (data, strobes, last)
//   b*_o  / bready_i             write response channel
//   ar*_i / arready_o            read address channel
//   r*_o  / rready_i             read data channel
//   mem_req_o, mem_we_o          RAM request / write enable
//   mem_be_o, mem_addr_o         RAM byte enables / word address
//   mem_data_o, mem_data_i       RAM write data / registered read data
//
// Optional feature: define PERIPHERAL_MPRAM_AXI4_WRAP_EN to honour WRAP bursts
// (len 1/3/7/15); otherwise WRAP is handled as INCR.

module peripheral_mpram_axi4_bridge #(
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    localparam int STRB_W = AXI_DATA_WIDTH / 8,
    localparam int OFS_W  = $clog2(STRB_W),
    localparam int BAW    = AXI_ADDR_WIDTH + OFS_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AXI_ID_WIDTH-1:0]   awid_i,
    input  logic [BAW-1:0]            awaddr_i,
    input  logic [7:0]                awlen_i,
    input  logic [1:0]                awburst_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]         wstrb_i,
    input  logic                      wlast_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [AXI_ID_WIDTH-1:0]   bid_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    input  logic [AXI_ID_WIDTH-1:0]   arid_i,
    input  logic [BAW-1:0]            araddr_i,
    input  logic [7:0]                arlen_i,
    input  logic [1:0]                arburst_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    output logic [AXI_ID_WIDTH-1:0]   rid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [STRB_W-1:0]         mem_be_o,
    output logic [AXI_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_data_o,
    input  logic [AXI_DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {S_IDLE, S_WBEAT, S_BRESP, S_RREQ, S_RDATA} state_t;

    state_t                    state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc, addr_next;
    logic [7:0]                len_q, len_d, cnt_q, cnt_d;
    logic                      err_q, err_d, wrap_q, wrap_d;
    logic                      last;

    // Shared capture path for both address channels; AW has priority.
    logic                      cap_aw;
    logic [AXI_ID_WIDTH-1:0]   cap_id;
    logic [BAW-1:0]            cap_addr;
    logic [7:0]                cap_len;
    logic [1:0]                cap_burst;

    // Byte-offset bits and (without WRAP support) the burst type carry no
    // information for this bridge; they are folded into a deliberately unused sink.
    logic unused_inputs;
    assign unused_inputs = ^{awaddr_i, araddr_i, awburst_i, arburst_i, cap_burst};

    assign cap_aw    = awvalid_i;
    assign cap_id    = cap_aw ? awid_i    : arid_i;
    assign cap_addr  = cap_aw ? awaddr_i  : araddr_i;
    assign cap_len   = cap_aw ? awlen_i   : arlen_i;
    assign cap_burst = cap_aw ? awburst_i : arburst_i;

    assign last     = (cnt_q == len_q);
    assign addr_inc = addr_q + 1'b1;

`ifdef PERIPHERAL_MPRAM_AXI4_WRAP_EN
    // WRAP: only the low log2(len+1) bits advance, upper bits stay at the block base.
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
    assign wrap_mask = {{(AXI_ADDR_WIDTH-4){1'b0}}, len_q[3:0]};
    assign addr_next = wrap_q ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
`else
    assign addr_next = wrap_q ? addr_inc : addr_inc;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wrap_d     = wrap_q;
        awready_o  = 1'b0;
        arready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        bid_o      = '0;
        bresp_o    = 2'b00;
        rvalid_o   = 1'b0;
        rid_o      = '0;
        rdata_o    = '0;
        rresp_o    = 2'b00;
        rlast_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_data_o = '0;

        case (state_q)
            S_IDLE: begin
                awready_o = awvalid_i;
                arready_o = arvalid_i & ~awvalid_i;
                if (awvalid_i || arvalid_i) begin
                    id_d    = cap_id;
                    addr_d  = cap_addr[BAW-1:OFS_W];
                    len_d   = cap_len;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    wrap_d  = 1'b0;
                    state_d = cap_aw ? S_WBEAT : S_RREQ;
`ifdef PERIPHERAL_MPRAM_AXI4_WRAP_EN
                    if (cap_burst == 2'b10) begin
                        if (cap_len == 8'd1 || cap_len == 8'd3 || cap_len == 8'd7 || cap_len == 8'd15)
                            wrap_d = 1'b1;
                        else
                            err_d = 1'b1;
                    end
`endif
                end
            end
            S_WBEAT: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_be_o   = wstrb_i;
                    mem_data_o = wdata_i;
                    mem_addr_o = addr_q;
                    addr_d     = addr_next;
                    cnt_d      = cnt_q + 8'd1;
                    // The counter ends the burst; a disagreeing wlast only flags an error.
                    if (wlast_i != last)
                        err_d = 1'b1;
                    if (last)
                        state_d = S_BRESP;
                end
            end
            S_BRESP: begin
                bvalid_o = 1'b1;
                bid_o    = id_q;
                bresp_o  = err_q ? 2'b10 : 2'b00;
                if (bready_i)
                    state_d = S_IDLE;
            end
            S_RREQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                state_d    = S_RDATA;
            end
            S_RDATA: begin
                rvalid_o   = 1'b1;
                rdata_o    = mem_data_i;
                rid_o      = id_q;
                rlast_o    = last;
                rresp_o    = err_q ? 2'b10 : 2'b00;
                // Address held so the RAM keeps presenting the same word while stalled.
                mem_addr_o = addr_q;
                if (rready_i) begin
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = S_RREQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_peripheral_mpram_axi4_bridge.sv
// tb/tb_peripheral_mpram_axi4_bridge.sv - scoreboard bench for the MPRAM AXI4 bridge

module tb_peripheral_mpram_axi4_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [11:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata, mem_data_o, mem_data_i;
    logic [3:0]  wstrb, mem_be;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready, rlast, rvalid, rready;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] model[0:1023];

    logic [31:0] ram[0:1023];
    logic [31:0] rd_q;

    peripheral_mpram_axi4_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awburst_i(awburst),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arburst_i(arburst),
        .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
        .rready_i(rready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_data_o[8*i +: 8];
            end else begin
                rd_q <= ram[mem_addr];
            end
        end
    end
    assign mem_data_i = rd_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_wrap(input logic [1:0] burst, input logic [7:0] len);
`ifdef PERIPHERAL_MPRAM_AXI4_WRAP_EN
        return (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [9:0] beat_addr(input logic [9:0] start, input logic [7:0] len,
                                             input int b, input logic wrap);
        logic [9:0] m;
        logic [9:0] s;
        m = {6'd0, len[3:0]};
        s = start + 10'(b);
        if (wrap) return (start & ~m) | (s & m);
        return s;
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [11:0] a, input logic [7:0] len,
                            input logic [1:0] burst);
        for (int b = 0; b <= int'(len); b++)
            exp_addr_q.push_back(beat_addr(a[11:2], len, b, is_wrap(burst, len)));
        awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        check("awready", awready, 1'b1);
        check("arready_blocked_by_aw", arready, 1'b0);
        tick;
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [31:0] base, input logic [3:0] strb,
                           input int bad_beat);
        logic [9:0] a;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = base + 32'(b); wstrb = strb;
            wlast = (b == int'(len)) || (b == bad_beat);
            #1;
            a = exp_addr_q.pop_front();
            check("wready", wready, 1'b1);
            check("arready_in_wbeat", arready, 1'b0);
            check("w_mem_req", mem_req, 1'b1);
            check("w_mem_we", mem_we, 1'b1);
            check("w_mem_addr", mem_addr, a);
            check("w_mem_be", mem_be, strb);
            check("w_mem_data", mem_data_o, base + 32'(b));
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[a][8*i +: 8] = wdata[8*i +: 8];
            tick;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id, input logic [1:0] resp);
        int n;
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        check("bvalid", bvalid, 1'b1);
        check("bid", bid, id);
        check("bresp", bresp, resp);
        check("b_no_mem_req", mem_req, 1'b0);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [11:0] a, input logic [7:0] len,
                            input logic [1:0] burst);
        logic [9:0] w;
        for (int b = 0; b <= int'(len); b++) begin
            w = beat_addr(a[11:2], len, b, is_wrap(burst, len));
            exp_addr_q.push_back(w);
            exp_data_q.push_back(model[w]);
        end
        arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        check("arready", arready, 1'b1);
        tick;
        arvalid = 1'b0;
    endtask

    task automatic r_phase(input logic [3:0] id, input logic [7:0] len, input int stall_beat,
                           input int abort_beat);
        int n;
        logic [9:0] a;
        logic [31:0] d;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 10) begin tick; n++; end
            a = exp_addr_q.pop_front();
            d = exp_data_q.pop_front();
            check("rvalid", rvalid, 1'b1);
            check("rid", rid, id);
            check("r_mem_addr", mem_addr, a);
            check("rdata", rdata, d);
            check("rlast", rlast, b == int'(len));
            check("rresp", rresp, 2'b00);
            if (b == abort_beat) return;
            if (b == stall_beat) begin
                for (int s = 0; s < 5; s++) begin
                    tick;
                    check("stall_rvalid", rvalid, 1'b1);
                    check("stall_rdata", rdata, d);
                    check("stall_mem_addr", mem_addr, a);
                    check("stall_no_req", mem_req, 1'b0);
                end
            end
            rready = 1'b1;
            tick;
            rready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        tick; tick; tick;
        rst = 1'b0;
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 10'd0);
        check("rst_bid", bid, 4'd0);

        // 4-beat INCR write at 0x10 then read back
        aw_phase(4'd3, 12'h010, 8'd3, 2'b01);
        w_phase(8'd3, 32'h000000A0, 4'hF, -1);
        b_phase(4'd3, 2'b00);
        ar_phase(4'd5, 12'h010, 8'd3, 2'b01);
        r_phase(4'd5, 8'd3, -1, -1);

        // partial strobes over a preloaded word
        aw_phase(4'd1, 12'h040, 8'd0, 2'b01);
        w_phase(8'd0, 32'hFFFFFFFF, 4'hF, -1);
        b_phase(4'd1, 2'b00);
        aw_phase(4'd1, 12'h040, 8'd0, 2'b01);
        w_phase(8'd0, 32'h11223344, 4'b0101, -1);
        b_phase(4'd1, 2'b00);
        ar_phase(4'd2, 12'h040, 8'd0, 2'b01);
        check("merged_word_model", exp_data_q[0], 32'hFF22FF44);
        r_phase(4'd2, 8'd0, -1, -1);

        // AW and AR together: AW first, AR only after B handshake
        arid = 4'd7; araddr = 12'h080; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        aw_phase(4'd2, 12'h080, 8'd0, 2'b01);
        w_phase(8'd0, 32'h5A5A1234, 4'hF, -1);
        b_phase(4'd2, 2'b00);
        ar_phase(4'd7, 12'h080, 8'd0, 2'b01);
        r_phase(4'd7, 8'd0, -1, -1);

        // read with a 5-cycle rready stall on beat 1
        ar_phase(4'd4, 12'h010, 8'd3, 2'b01);
        r_phase(4'd4, 8'd3, 1, -1);

        // early wlast -> both beats still written, SLVERR
        aw_phase(4'd6, 12'h100, 8'd1, 2'b01);
        w_phase(8'd1, 32'h000000B0, 4'hF, 0);
        b_phase(4'd6, 2'b10);
        ar_phase(4'd6, 12'h100, 8'd1, 2'b01);
        r_phase(4'd6, 8'd1, -1, -1);

        // FIXED burst at top word with byte offset set: wraps 1023 -> 0
        aw_phase(4'd8, 12'hFFF, 8'd1, 2'b00);
        w_phase(8'd1, 32'h000000C0, 4'hF, -1);
        b_phase(4'd8, 2'b00);
        ar_phase(4'd8, 12'hFFC, 8'd1, 2'b11);
        r_phase(4'd8, 8'd1, -1, -1);

        // reset during beat 2 of a 4-beat read, then a fresh read
        ar_phase(4'd9, 12'h010, 8'd3, 2'b01);
        r_phase(4'd9, 8'd3, -1, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_rvalid", rvalid, 1'b0);
        check("rst_mid_mem_req", mem_req, 1'b0);
        check("rst_mid_rid", rid, 4'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        ar_phase(4'd10, 12'h010, 8'd3, 2'b01);
        r_phase(4'd10, 8'd3, -1, -1);

        // WRAP burst at word 6 (6,7,4,5 when WRAP support is built in, else 6..9)
        aw_phase(4'd11, 12'h018, 8'd3, 2'b10);
        w_phase(8'd3, 32'h000000D0, 4'hF, -1);
        b_phase(4'd11, 2'b00);
        ar_phase(4'd11, 12'h018, 8'd3, 2'b10);
        r_phase(4'd11, 8'd3, -1, -1);
`ifdef PERIPHERAL_MPRAM_AXI4_WRAP_EN
        aw_phase(4'd12, 12'h200, 8'd2, 2'b10);
        w_phase(8'd2, 32'h000000E0, 4'hF, -1);
        b_phase(4'd12, 2'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
